// File: rtl/bypass_scoreboard.sv
// Operand bypass scoreboard: tracks in-flight results behind EX, forwards the
// youngest matching result to each EX read port and stalls on unarrived loads.
module bypass_scoreboard #(
  parameter int WIDTH      = 32,
  parameter int NREAD      = 2,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_valid,
  input  logic                   ex_we,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic [WIDTH-1:0]       ex_result,
  input  logic [WIDTH-1:0]       ld_data,
  input  logic                   flush,
  input  logic [NREAD*5-1:0]     ex_rs,
  input  logic [NREAD*WIDTH-1:0] rf_data,
  output logic [NREAD*WIDTH-1:0] opnd,
  output logic [NREAD*3-1:0]     fwd_sel,
  output logic                   stall,
  output logic                   wb_valid,
  output logic [4:0]             wb_rd,
  output logic [WIDTH-1:0]       wb_data,
  output logic [15:0]            stall_cnt
);

  // Index i holds stage i+1 (index 0 = MEM, index DEPTH-1 = WB).
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] we_r;
  logic [DEPTH-1:0] load_r;
  logic [4:0]       rd_r   [DEPTH];
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [15:0]      stall_cnt_r;

  logic [DEPTH-1:0] ready_s;
  logic [NREAD-1:0] port_stall_s;
  logic             stall_s;
  logic             accept_s;
  logic [4:0]       rs_s;
  logic             hit_s;
  logic             sel_ready_s;
  logic [2:0]       sel_stage_s;
  logic [WIDTH-1:0] sel_data_s;

  function automatic logic stage_match(input logic v, input logic we,
                                       input logic [4:0] rd, input logic [4:0] rs);
    return v && we && (rd == rs) && (rs != 5'd0);
  endfunction

  // A load entry only carries valid data once it has moved past the load stage.
  always_comb begin
    ready_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (load_r[i] && ((i + 1) <= LOAD_STAGE)) begin
        ready_s[i] = 1'b0;
      end else begin
        ready_s[i] = 1'b1;
      end
    end
  end

  // Per-port selection: scanning oldest to youngest lets the youngest match win.
  always_comb begin
    opnd         = rf_data;
    fwd_sel      = '0;
    port_stall_s = '0;
    rs_s         = 5'd0;
    hit_s        = 1'b0;
    sel_ready_s  = 1'b0;
    sel_stage_s  = 3'd0;
    sel_data_s   = '0;
    for (int p = 0; p < NREAD; p++) begin
      rs_s        = ex_rs[p*5 +: 5];
      hit_s       = 1'b0;
      sel_ready_s = 1'b0;
      sel_stage_s = 3'd0;
      sel_data_s  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (stage_match(valid_r[i], we_r[i], rd_r[i], rs_s)) begin
          hit_s       = 1'b1;
          sel_ready_s = ready_s[i];
          sel_stage_s = 3'(i + 1);
          sel_data_s  = data_r[i];
        end else begin
          hit_s       = hit_s;
        end
      end
      if (hit_s && sel_ready_s) begin
        opnd[p*WIDTH +: WIDTH] = sel_data_s;
        fwd_sel[p*3 +: 3]      = sel_stage_s;
      end else if (hit_s) begin
        port_stall_s[p] = 1'b1;
      end else begin
        port_stall_s[p] = 1'b0;
      end
    end
  end

  assign stall_s  = ex_valid & (|port_stall_s);
  assign accept_s = ex_valid & ~stall_s & ~flush;
  assign stall    = stall_s;

  // Pipeline advance: EX enters stage 1 (or a bubble), older stages shift down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      we_r    <= '0;
      load_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_r[i]   <= 5'd0;
        data_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= accept_s;
      we_r[0]    <= ex_we;
      load_r[0]  <= ex_is_load;
      rd_r[0]    <= ex_rd;
      data_r[0]  <= ex_result;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        we_r[i]    <= we_r[i-1];
        load_r[i]  <= load_r[i-1];
        rd_r[i]    <= rd_r[i-1];
        // Load data replaces the address as the entry leaves the load stage.
        if ((i == LOAD_STAGE) && valid_r[i-1] && load_r[i-1]) begin
          data_r[i] <= ld_data;
        end else begin
          data_r[i] <= data_r[i-1];
        end
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign wb_valid  = valid_r[DEPTH-1] & we_r[DEPTH-1];
  assign wb_rd     = rd_r[DEPTH-1];
  assign wb_data   = data_r[DEPTH-1];

endmodule
